// File: rtl/conv_frame_writer.sv
// Frame writer for a convolution engine: drops leading garbage and window-wrap columns,
// then buffers kept pixels with their output-image address and issues them as memory writes.
module conv_frame_writer #(
  parameter int WORD_SIZE  = 8,
  parameter int ROW_SIZE   = 540,
  parameter int NUM_ROWS   = 540,
  parameter int SKIP_COUNT = 4,
  parameter int FIFO_DEPTH = 16,
  localparam int ADDR_W    = $clog2((ROW_SIZE-2)*(NUM_ROWS-2))
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_pixel,
  output logic                 wr_en,
  input  logic                 wr_ready,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [WORD_SIZE-1:0] wr_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int COL_W  = $clog2(ROW_SIZE);
  localparam int ROW_W  = $clog2(NUM_ROWS);
  localparam int SKIP_W = (SKIP_COUNT > 1) ? $clog2(SKIP_COUNT) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [COL_W-1:0]  COL_KEEP_MAX = COL_W'(ROW_SIZE - 3);
  localparam logic [COL_W-1:0]  COL_MAX      = COL_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST     = ROW_W'(NUM_ROWS - 3);
  localparam logic [SKIP_W-1:0] SKIP_LAST    = SKIP_W'((SKIP_COUNT > 0) ? SKIP_COUNT - 1 : 0);
  localparam logic [CNT_W-1:0]  FIFO_FULL    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SKIP, STREAM, DRAIN} state_t;

  state_t state_reg, state_next;

  logic [SKIP_W-1:0] skip_cnt_reg;
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              overflow_reg;

  logic [ADDR_W-1:0]    mem_addr [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic                 wr_en_reg;
  logic [ADDR_W-1:0]    wr_addr_reg;
  logic [WORD_SIZE-1:0] wr_data_reg;

  logic arm, in_stream, keep, last_kept, full, pop, push, drop;

  assign arm        = (state_reg == IDLE) && start;
  assign in_stream  = (state_reg == STREAM) && in_valid;
  assign keep       = in_stream && (col_reg <= COL_KEEP_MAX);
  assign last_kept  = keep && (row_reg == ROW_LAST) && (col_reg == COL_KEEP_MAX);
  assign full       = (count_reg == FIFO_FULL);
  assign pop        = wr_en_reg && wr_ready;
  // A full buffer can still take a beat when the head leaves in the same cycle.
  assign push       = keep && (!full || pop);
  assign drop       = keep && full && !pop;
  assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign busy     = (state_reg != IDLE);
  assign overflow = overflow_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    frame_done = 1'b0;
    case (state_reg)
      IDLE:   if (start) state_next = (SKIP_COUNT == 0) ? STREAM : SKIP;
      SKIP:   if (in_valid && (skip_cnt_reg == SKIP_LAST)) state_next = STREAM;
      STREAM: if (last_kept) state_next = DRAIN;
      DRAIN: begin
        if (count_reg == '0) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address is a running count of kept beats, which equals row*(ROW_SIZE-2)+col.
  always_ff @(posedge clk) begin
    if (rst || arm) begin
      skip_cnt_reg <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
      addr_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if ((state_reg == SKIP) && in_valid) skip_cnt_reg <= skip_cnt_reg + SKIP_W'(1);
      if (in_stream) begin
        if (col_reg == COL_MAX) begin
          col_reg <= '0;
          row_reg <= row_reg + ROW_W'(1);
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end
      if (keep) addr_reg <= addr_reg + ADDR_W'(1);
      if (drop) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_reg] <= addr_reg;
      mem_data[wr_ptr_reg] <= in_pixel;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + CNT_W'(1);
    else if (pop && !push) count_next = count_reg - CNT_W'(1);
  end

  // Output registers always hold the post-update head so wr_addr/wr_data are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_inc;
      count_reg <= count_next;
      wr_en_reg <= (count_next != '0);
      if (pop) begin
        if (count_reg > CNT_W'(1)) begin
          wr_addr_reg <= mem_addr[rd_ptr_inc];
          wr_data_reg <= mem_data[rd_ptr_inc];
        end else if (push) begin
          wr_addr_reg <= addr_reg;
          wr_data_reg <= in_pixel;
        end
      end else if ((count_reg == '0) && push) begin
        wr_addr_reg <= addr_reg;
        wr_data_reg <= in_pixel;
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_writer.sv
// Directed bench for conv_frame_writer on a 5x4 frame, 2 skipped beats, 4-entry buffer.
module tb_conv_frame_writer;

  localparam int WORD_SIZE = 8;
  localparam int ADDR_W    = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 in_valid = 1'b0;
  logic [WORD_SIZE-1:0] in_pixel = '0;
  logic                 wr_en;
  logic                 wr_ready = 1'b1;
  logic [ADDR_W-1:0]    wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 busy;
  logic                 frame_done;
  logic                 overflow;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int wa[$];
  int wd[$];
  int exp_data[6] = '{2, 3, 4, 7, 8, 9};

  conv_frame_writer #(
    .WORD_SIZE(WORD_SIZE), .ROW_SIZE(5), .NUM_ROWS(4), .SKIP_COUNT(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_pixel(in_pixel),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en && wr_ready) begin
        wa.push_back(int'(wr_addr));
        wd.push_back(int'(wr_data));
        $display("write addr=%0d data=%0d", wr_addr, wr_data);
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    fd_cnt = 0;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: back-to-back beats; 1: gapped beats with a 10-cycle stall on the first write;
  // 2: gapped beats with a stray start pulse mid-stream.
  task automatic feed(input int n, input int mode);
    int stall = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_pixel = WORD_SIZE'(i);
      tick();
      if (mode == 1 && wr_en && !wr_ready) begin
        check("bp_addr_hold", wr_addr, 0);
        check("bp_data_hold", wr_data, 2);
        stall++;
        if (stall == 10) wr_ready = 1'b1;
      end
      if (mode != 0) begin
        in_valid = 1'b0;
        if (mode == 2 && i == 5) start = 1'b1;
        tick();
        start = 1'b0;
        if (mode == 1 && wr_en && !wr_ready) begin
          check("bp_addr_hold", wr_addr, 0);
          check("bp_data_hold", wr_data, 2);
          stall++;
          if (stall == 10) wr_ready = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_count"}, wa.size(), n);
    for (int j = 0; j < n; j++) begin
      check({tag, "_addr"}, (j < wa.size()) ? wa[j] : -1, j);
      check({tag, "_data"}, (j < wd.size()) ? wd[j] : -1, exp_data[j]);
    end
  endtask

  initial begin
    // Reset state
    tick();
    rst = 1'b0;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);

    // Beats in IDLE are ignored
    in_valid = 1'b1;
    in_pixel = 8'd77;
    tick(); tick();
    in_valid = 1'b0;
    check("idle_ignore_busy", busy, 0);
    check("idle_ignore_wr_en", wr_en, 0);

    // Nominal frame
    clear_log();
    wr_ready = 1'b1;
    arm();
    check("nom_busy", busy, 1);
    feed(20, 0);
    for (int k = 0; k < 10; k++) tick();
    check_writes("nom", 6);
    check("nom_done_pulses", fd_cnt, 1);
    check("nom_busy_end", busy, 0);
    check("nom_overflow", overflow, 0);

    // Backpressure: beats spaced so the 4-entry buffer absorbs the stall
    clear_log();
    wr_ready = 1'b0;
    arm();
    feed(20, 1);
    for (int k = 0; k < 10; k++) tick();
    check("bp_ready_released", wr_ready, 1);
    check_writes("bp", 6);
    check("bp_done_pulses", fd_cnt, 1);
    check("bp_overflow", overflow, 0);

    // Overflow: no writes accepted for the whole frame
    clear_log();
    wr_ready = 1'b0;
    arm();
    feed(20, 0);
    check("ovf_flag", overflow, 1);
    check("ovf_busy_drain", busy, 1);
    check("ovf_wr_en", wr_en, 1);
    check("ovf_head_addr", wr_addr, 0);
    check("ovf_head_data", wr_data, 2);
    check("ovf_no_writes", wa.size(), 0);
    check("ovf_no_done", fd_cnt, 0);
    wr_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check_writes("ovf", 4);
    check("ovf_done_pulses", fd_cnt, 1);
    check("ovf_busy_end", busy, 0);
    check("ovf_sticky", overflow, 1);

    // Reset mid-frame with entries buffered and overflow set
    clear_log();
    wr_ready = 1'b0;
    arm();
    check("mid_overflow_cleared_on_start", overflow, 0);
    feed(11, 0);
    check("mid_pre_wr_en", wr_en, 1);
    check("mid_pre_overflow", overflow, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_wr_en", wr_en, 0);
    check("mid_busy", busy, 0);
    check("mid_overflow", overflow, 0);
    check("mid_wr_addr", wr_addr, 0);
    wr_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("mid_no_writes", wa.size(), 0);
    check("mid_no_done", fd_cnt, 0);
    arm();
    feed(20, 0);
    for (int k = 0; k < 10; k++) tick();
    check_writes("mid_restart", 6);
    check("mid_restart_done", fd_cnt, 1);

    // Gapped input with a start pulse during STREAM
    clear_log();
    wr_ready = 1'b1;
    arm();
    feed(20, 2);
    for (int k = 0; k < 10; k++) tick();
    check_writes("gap", 6);
    check("gap_done_pulses", fd_cnt, 1);
    check("gap_busy_end", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
